// File: rtl/writeback_queue.sv
// In-order write-back buffer in front of the register bank's single write port.
// Merges ALU and load results, retires one per clock, and forwards queued data.
module writeback_queue #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 5,
  parameter  int DW    = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          wb_w,
  output logic [AW-1:0] wb_c,
  output logic [DW-1:0] wb_data,
  input  logic [AW-1:0] rd_a,
  input  logic [AW-1:0] rd_b,
  output logic          fwd_a_hit,
  output logic [DW-1:0] fwd_a_data,
  output logic          fwd_b_hit,
  output logic [DW-1:0] fwd_b_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW-1:0] ZR     = {AW{1'b1}};
  localparam logic [CW-1:0] CNT_M1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_M2 = CW'(DEPTH - 2);
  localparam logic [CW-1:0] CNT_F  = CW'(DEPTH);

  logic [DEPTH-1:0][AW-1:0] rd_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d, alu_slot;
  logic [CW-1:0]            count_q, count_d;
  logic                     pop, mem_push, alu_push;
  logic [PW-1:0]            fidx;

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_F);
  assign mem_ready = (count_q <= CNT_M1);
  // ALU yields the last free slot to a concurrently offered load.
  assign alu_ready = mem_valid ? (count_q <= CNT_M2) : (count_q <= CNT_M1);

  assign wb_w    = !empty;
  assign wb_c    = empty ? '0 : rd_q[head_q];
  assign wb_data = empty ? '0 : data_q[head_q];

  always_comb begin
    pop      = !empty;
    mem_push = mem_valid && mem_ready && (mem_rd != ZR);
    alu_push = alu_valid && alu_ready && (alu_rd != ZR);
    alu_slot = tail_q + PW'(mem_push);
    head_d   = head_q + PW'(pop);
    tail_d   = tail_q + PW'(mem_push) + PW'(alu_push);
    count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    vld_d    = vld_q;
    if (pop)      vld_d[head_q]   = 1'b0;
    if (mem_push) vld_d[tail_q]   = 1'b1;
    if (alu_push) vld_d[alu_slot] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Entry payload needs no reset; vld_q qualifies every use of it.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      rd_q[tail_q]   <= mem_rd;
      data_q[tail_q] <= mem_data;
    end
    if (alu_push) begin
      rd_q[alu_slot]   <= alu_rd;
      data_q[alu_slot] <= alu_data;
    end
  end

  // Walk oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    fwd_a_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_hit  = 1'b0;
    fwd_b_data = '0;
    fidx       = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = head_q + PW'(i);
      if (vld_q[fidx] && rd_q[fidx] == rd_a && rd_a != ZR) begin
        fwd_a_hit  = 1'b1;
        fwd_a_data = data_q[fidx];
      end
      if (vld_q[fidx] && rd_q[fidx] == rd_b && rd_b != ZR) begin
        fwd_b_hit  = 1'b1;
        fwd_b_data = data_q[fidx];
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (DEPTH=4, AW=5, DW=64).
module tb_writeback_queue;
  logic        clk = 0, rst_n = 0;
  logic        alu_valid = 0, mem_valid = 0;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd = 0, mem_rd = 0, rd_a = 0, rd_b = 0;
  logic [63:0] alu_data = 0, mem_data = 0;
  logic        wb_w, fwd_a_hit, fwd_b_hit, full, empty;
  logic [4:0]  wb_c;
  logic [63:0] wb_data, fwd_a_data, fwd_b_data;
  logic [2:0]  count;
  int total = 0, bad = 0;

  writeback_queue #(.DEPTH(4), .AW(5), .DW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_w(wb_w), .wb_c(wb_c), .wb_data(wb_data),
    .rd_a(rd_a), .rd_b(rd_b),
    .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
    .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); rd_a = 0; rd_b = 0;
    cyc(); cyc();
    total++; if (wb_w !== 1'b0)  begin bad++; $display("FAIL rst_wb_w got %b want 0", wb_w); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got %0d want 0", count); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL rst_flags got e=%b f=%b want e=1 f=0", empty, full); end
    total++; if (fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0) begin bad++; $display("FAIL rst_fwd got %b%b want 00", fwd_a_hit, fwd_b_hit); end
    rst_n = 1; cyc();
  endtask

  task automatic test_single_push();
    alu_valid = 1; alu_rd = 3; alu_data = 64'h1122334455667788; #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL single_ready got %b want 1", alu_ready); end
    cyc(); idle(); #1;
    total++; if (wb_w !== 1'b1 || wb_c !== 5'd3 || wb_data !== 64'h1122334455667788)
      begin bad++; $display("FAIL single_wb got w=%b c=%0d d=%h want w=1 c=3 d=1122334455667788", wb_w, wb_c, wb_data); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got %0d want 1", count); end
    cyc();
    total++; if (wb_w !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL single_drain got w=%b e=%b want w=0 e=1", wb_w, empty); end
  endtask

  task automatic test_dual_order();
    mem_valid = 1; mem_rd = 5; mem_data = 64'hA; alu_valid = 1; alu_rd = 6; alu_data = 64'hB; #1;
    total++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin bad++; $display("FAIL dual_ready got m=%b a=%b want 11", mem_ready, alu_ready); end
    cyc(); idle(); #1;
    total++; if (count !== 3'd2) begin bad++; $display("FAIL dual_count got %0d want 2", count); end
    total++; if (wb_w !== 1'b1 || wb_c !== 5'd5 || wb_data !== 64'hA) begin bad++; $display("FAIL dual_wb0 got c=%0d d=%h want c=5 d=a", wb_c, wb_data); end
    cyc();
    total++; if (wb_w !== 1'b1 || wb_c !== 5'd6 || wb_data !== 64'hB) begin bad++; $display("FAIL dual_wb1 got c=%0d d=%h want c=6 d=b", wb_c, wb_data); end
    cyc();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL dual_empty got %b want 1", empty); end
  endtask

  task automatic test_forward();
    rd_a = 7; rd_b = 9;
    mem_valid = 1; mem_rd = 7; mem_data = 64'd1; alu_valid = 1; alu_rd = 7; alu_data = 64'd2; #1;
    total++; if (fwd_a_hit !== 1'b0) begin bad++; $display("FAIL fwd_same_cycle got %b want 0", fwd_a_hit); end
    cyc(); idle(); #1;
    total++; if (fwd_a_hit !== 1'b1 || fwd_a_data !== 64'd2) begin bad++; $display("FAIL fwd_youngest got h=%b d=%0d want h=1 d=2", fwd_a_hit, fwd_a_data); end
    total++; if (fwd_b_hit !== 1'b0 || fwd_b_data !== 64'd0) begin bad++; $display("FAIL fwd_b_miss got h=%b d=%0d want h=0 d=0", fwd_b_hit, fwd_b_data); end
    rd_b = 7; rd_a = 31; #1;
    total++; if (fwd_a_hit !== 1'b0) begin bad++; $display("FAIL fwd_xzr got %b want 0", fwd_a_hit); end
    total++; if (fwd_b_hit !== 1'b1 || fwd_b_data !== 64'd2) begin bad++; $display("FAIL fwd_b_hit got h=%b d=%0d want h=1 d=2", fwd_b_hit, fwd_b_data); end
    cyc();
    total++; if (fwd_b_hit !== 1'b1 || fwd_b_data !== 64'd2 || wb_c !== 5'd7) begin bad++; $display("FAIL fwd_head got h=%b d=%0d c=%0d want h=1 d=2 c=7", fwd_b_hit, fwd_b_data, wb_c); end
    cyc();
    total++; if (fwd_b_hit !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL fwd_gone got h=%b e=%b want h=0 e=1", fwd_b_hit, empty); end
    rd_a = 0; rd_b = 0;
  endtask

  task automatic test_backpressure();
    mem_valid = 1; alu_valid = 1; mem_rd = 1; alu_rd = 2; mem_data = 64'h11; alu_data = 64'h22;
    cyc();
    mem_rd = 3; alu_rd = 4; mem_data = 64'h33; alu_data = 64'h44; #1;
    total++; if (count !== 3'd2 || alu_ready !== 1'b1 || wb_c !== 5'd1) begin bad++; $display("FAIL bp_c2 got n=%0d ar=%b c=%0d want n=2 ar=1 c=1", count, alu_ready, wb_c); end
    cyc();
    mem_rd = 5; alu_rd = 6; mem_data = 64'h55; alu_data = 64'h66; #1;
    total++; if (count !== 3'd3 || mem_ready !== 1'b1 || alu_ready !== 1'b0 || full !== 1'b0)
      begin bad++; $display("FAIL bp_c3 got n=%0d mr=%b ar=%b f=%b want n=3 mr=1 ar=0 f=0", count, mem_ready, alu_ready, full); end
    total++; if (wb_c !== 5'd2) begin bad++; $display("FAIL bp_head2 got %0d want 2", wb_c); end
    cyc(); idle(); #1;
    total++; if (count !== 3'd3 || wb_c !== 5'd3) begin bad++; $display("FAIL bp_steady got n=%0d c=%0d want n=3 c=3", count, wb_c); end
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL bp_alu_alone got %b want 1", alu_ready); end
    cyc();
    total++; if (wb_c !== 5'd4 || wb_data !== 64'h44) begin bad++; $display("FAIL bp_drain4 got c=%0d d=%h want c=4 d=44", wb_c, wb_data); end
    cyc();
    total++; if (wb_c !== 5'd5 || wb_data !== 64'h55) begin bad++; $display("FAIL bp_drain5 got c=%0d d=%h want c=5 d=55", wb_c, wb_data); end
    cyc();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL bp_empty got %b want 1", empty); end
  endtask

  task automatic test_xzr();
    alu_valid = 1; alu_rd = 31; alu_data = 64'hDEAD; #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL xzr_ready got %b want 1", alu_ready); end
    cyc(); idle(); #1;
    total++; if (count !== 3'd0 || wb_w !== 1'b0) begin bad++; $display("FAIL xzr_noop got n=%0d w=%b want n=0 w=0", count, wb_w); end
    mem_valid = 1; mem_rd = 31; alu_valid = 1; alu_rd = 10; alu_data = 64'hAB;
    cyc(); idle(); #1;
    total++; if (count !== 3'd1 || wb_c !== 5'd10 || wb_data !== 64'hAB) begin bad++; $display("FAIL xzr_mix got n=%0d c=%0d d=%h want n=1 c=10 d=ab", count, wb_c, wb_data); end
    cyc();
  endtask

  task automatic test_reset_mid();
    mem_valid = 1; alu_valid = 1; mem_rd = 12; alu_rd = 13;
    cyc(); mem_rd = 14; alu_rd = 15; cyc(); idle(); #1;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL mid_pre got %0d want 3", count); end
    #1 rst_n = 0; #1;
    total++; if (wb_w !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL mid_rst got w=%b n=%0d e=%b want w=0 n=0 e=1", wb_w, count, empty); end
    alu_valid = 1; alu_rd = 20; cyc();
    total++; if (wb_w !== 1'b0) begin bad++; $display("FAIL mid_hold got %b want 0", wb_w); end
    idle(); rst_n = 1; cyc();
    total++; if (wb_w !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL mid_stale got w=%b e=%b want w=0 e=1", wb_w, empty); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_dual_order();
    test_forward();
    test_backpressure();
    test_xzr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Write-back stage directly upstream of the register bank's single write port (write-enable, write address, write data).
- Accepts 64-bit results from two producers: the ALU path and the load/memory path.
- Buffers results in a small in-order FIFO and retires one entry per clock into the register bank.
- Provides forwarding lookups so operand reads can see results that are queued but not yet written.

Parameters:
DEPTH, 4, number of FIFO entries (power of two, >= 2)
AW, 5, register address width
DW, 64, register data width

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous reset, active-low
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU result accepted this cycle when alu_valid=1
alu_rd  input  AW  ALU destination register
alu_data  input  DW  ALU result
mem_valid  input  1  load result offered
mem_ready  output  1  load result accepted this cycle when mem_valid=1
mem_rd  input  AW  load destination register
mem_data  input  DW  load result
wb_w  output  1  write enable to register bank
wb_c  output  AW  write address to register bank
wb_data  output  DW  write data to register bank
rd_a  input  AW  forwarding lookup address A (same as bank read address a)
rd_b  input  AW  forwarding lookup address B
fwd_a_hit  output  1  youngest queued entry matching rd_a exists
fwd_a_data  output  DW  data of that entry; 0 when no hit
fwd_b_hit  output  1  same, for rd_b
fwd_b_data  output  DW  same, for rd_b
count  output  clog2(DEPTH)+1  current occupancy
full  output  1  count==DEPTH
empty  output  1  count==0

Behaviour:
- **Reset (rst_n=0, asynchronous):**
  - Pointers and count clear to 0; all entry-valid flags clear.
  - Outputs: wb_w=0, full=0, empty=1, fwd hits=0.
  - Entry data is don't-care.
  - A reset mid-operation discards all queued entries; no write is issued in any cycle while rst_n=0.
- **Head output (combinational from registered state):**
  - wb_w = !empty; wb_c and wb_data come from the head entry.
  - When empty, wb_c=0 and wb_data=0.
  - The bank always accepts a presented write, so the head pops at every posedge where !empty.
- **Acceptance uses registered count only.** A same-cycle pop does not free a slot.
  - mem_ready = (count <= DEPTH-1).
  - alu_ready = mem_valid ? (count <= DEPTH-2) : (count <= DEPTH-1).
- **Ordering:**
  - When both producers are accepted in the same cycle, the mem entry is enqueued first (older) and the ALU entry second.
  - Both writes land at the same edge.
- **Zero register:** a handshake with rd==31 (XZR) completes normally (ready honoured) but enqueues nothing and does not change count.
- **Latency:** a result accepted at edge N appears on wb_w/wb_c/wb_data during cycle N..N+1 and is written into the bank at edge N+1 (if it is the head).
- **Count update:** count_next = count + pushes − pop.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle at full or empty boundaries must be exact: an empty queue with 1 push and 0 pop gives count=1; a full queue with a pop cannot push.
- **Forwarding:**
  - Search valid entries youngest-first; the first match on rd_a or rd_b wins.
  - rd==31 never hits.
  - The head entry being written this cycle still counts as a hit.
  - Results enqueued this same cycle are NOT visible until the next cycle.
- Only the mem port is guaranteed progress when count==DEPTH-1. The ALU stalls if a mem push is also offered.

Test Plan:
1. Reset, then ALU push rd=3, data=0x1122334455667788 -> next cycle wb_w=1, wb_c=3, wb_data=0x1122334455667788; the cycle after, wb_w=0, empty=1.
2. Same cycle: mem rd=5 data=0xA and ALU rd=6 data=0xB, count=0 -> count=2; wb sequence is (5,0xA) then (6,0xB) on consecutive cycles.
3. Push rd=7 data=1, then rd=7 data=2, with rd_a=7 -> fwd_a_hit=1 and fwd_a_data=2 while both are queued; rd_a=31 gives hit=0.
4. Fill to count=3 (DEPTH=4) with both ports valid -> mem_ready=1, alu_ready=0; count becomes 3+1−1=3 after the pop; at count=4, full=1 and both ready=0.
5. ALU push with rd=31 -> alu_ready=1, count unchanged, no wb_w pulse.
6. Queue holding 3 entries, assert rst_n=0 mid-cycle -> wb_w=0 immediately, count=0, empty=1; after release, no stale write appears.
